onehot_moore_seq: RTL and testbench

- Parametrised one-hot Moore sequencer: N_STATES stages, each advanced or stepped back by a per-stage qualifier input.
- Moore outputs come from a per-state lookup parameter.
- Adds a per-stage dwell timeout, illegal-encoding recovery, sticky error flags and a completion pulse.
- Serves as the general control FSM for exam/lab datapaths that previously needed hand-written fixed 4-state machines.

---
 rtl/onehot_moore_seq.sv | 113 +++++++++++
 tb/tb_onehot_moore_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_moore_seq.sv
// One-hot Moore sequencer: per-stage advance/step-back qualifiers, table-driven
// Moore output, dwell timeout, illegal-encoding recovery and a wrap pulse.
module onehot_moore_seq #(
  parameter int                          N_STATES  = 4,
  parameter int                          OUT_W     = 2,
  parameter logic [N_STATES*OUT_W-1:0]   OUT_TABLE = 8'b11011001,
  parameter int                          CNT_W     = 8,
  parameter int                          TIMEOUT   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [N_STATES-1:0]           adv,
  input  logic [N_STATES-1:0]           back,
  input  logic                          err_clr,
  output logic [N_STATES-1:0]           state_oh,
  output logic [$clog2(N_STATES)-1:0]   state_idx,
  output logic [OUT_W-1:0]              z,
  output logic                          done,
  output logic [CNT_W-1:0]              dwell,
  output logic                          timeout_err,
  output logic                          illegal_err
);

  localparam int IDX_W = $clog2(N_STATES);
  localparam logic [N_STATES-1:0] STAGE0 = N_STATES'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    T_HOLD,
    T_ILLEGAL,
    T_CLR,
    T_ADV,
    T_BACK,
    T_TIMEOUT
  } trans_e;

  logic [N_STATES-1:0] state_q;
  logic [CNT_W-1:0]    dwell_q;
  logic                done_q;
  logic                to_err_q;
  logic                il_err_q;

  logic                legal;
  logic                adv_cur;
  logic                back_cur;
  logic                to_hit;
  trans_e              trans;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Exactly one bit set; anything else is an upset to be recovered from.
  assign legal = (state_q != '0) && ((state_q & (state_q - 1'b1)) == '0);

  always_comb begin
    state_idx = '0;
    if (legal) begin
      for (int i = 0; i < N_STATES; i++) begin
        if (state_q[i]) state_idx = IDX_W'(i);
      end
    end
  end

  assign z = legal ? OUT_TABLE[state_idx*OUT_W +: OUT_W] : '0;

  assign adv_cur  = |(adv & state_q);
  assign back_cur = |(back[N_STATES-1:1] & state_q[N_STATES-1:1]);
  assign to_hit   = (TIMEOUT != 0) && !state_q[0] && (dwell_q == TO_LAST);

  always_comb begin
    trans = T_HOLD;
    if (!legal)        trans = T_ILLEGAL;
    else if (clr)      trans = T_CLR;
    else if (adv_cur)  trans = T_ADV;
    else if (back_cur) trans = T_BACK;
    else if (to_hit)   trans = T_TIMEOUT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= STAGE0;
      dwell_q  <= '0;
      done_q   <= 1'b0;
      to_err_q <= 1'b0;
      il_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (en) begin
        case (trans)
          T_ILLEGAL, T_CLR, T_TIMEOUT: state_q <= STAGE0;
          T_ADV:  state_q <= {state_q[N_STATES-2:0], state_q[N_STATES-1]};
          T_BACK: state_q <= state_q >> 1;
          default: state_q <= state_q;
        endcase
        // Any transition, even clr re-entering stage 0, restarts the dwell count.
        dwell_q  <= (trans == T_HOLD) ? sat_inc(dwell_q) : '0;
        done_q   <= (trans == T_ADV) && state_q[N_STATES-1];
        to_err_q <= (trans == T_TIMEOUT) || (to_err_q && !err_clr);
        il_err_q <= (trans == T_ILLEGAL) || (il_err_q && !err_clr);
      end
    end
  end

  assign state_oh    = state_q;
  assign dwell       = dwell_q;
  assign done        = done_q;
  assign timeout_err = to_err_q;
  assign illegal_err = il_err_q;

endmodule

// File: tb/tb_onehot_moore_seq.sv
// Bench for onehot_moore_seq: a default build and a TIMEOUT=0 build share
// stimulus; an index-level model predicts both every cycle.
module tb_onehot_moore_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, err_clr;
  logic [3:0] adv, back;
  logic       inject;

  logic [3:0] st0, st1;
  logic [1:0] idx0, idx1, z0, z1;
  logic       done0, done1, to0, to1, il0, il1;
  logic [7:0] dw0, dw1;

  int checks = 0;
  int failures = 0;

  onehot_moore_seq dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .adv(adv), .back(back),
    .err_clr(err_clr), .state_oh(st0), .state_idx(idx0), .z(z0), .done(done0),
    .dwell(dw0), .timeout_err(to0), .illegal_err(il0));

  onehot_moore_seq #(.TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .adv(adv), .back(back),
    .err_clr(err_clr), .state_oh(st1), .state_idx(idx1), .z(z1), .done(done1),
    .dwell(dw1), .timeout_err(to1), .illegal_err(il1));

  always #5 clk = ~clk;

  // Model state per build: stage number, dwell count, registered flags.
  localparam int TO_V[2] = '{10, 0};
  logic [1:0] ZTAB[4] = '{2'b01, 2'b10, 2'b01, 2'b11};
  int m_cur[2]   = '{0, 0};
  int m_dwell[2] = '{0, 0};
  bit m_done[2]  = '{0, 0};
  bit m_to[2]    = '{0, 0};
  bit m_il[2]    = '{0, 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cur[i] = 0; m_dwell[i] = 0; m_done[i] = 0; m_to[i] = 0; m_il[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit moved, wrap, fire, ill;
        moved = 0; wrap = 0; fire = 0; ill = 0;
        if (!en) begin
          m_done[i] = 0;
        end else begin
          if (i == 0 && inject) begin
            ill = 1; moved = 1; m_cur[i] = 0;
          end else if (clr) begin
            moved = 1; m_cur[i] = 0;
          end else if (adv[m_cur[i]]) begin
            moved = 1; wrap = (m_cur[i] == 3); m_cur[i] = (m_cur[i] + 1) % 4;
          end else if (m_cur[i] != 0 && back[m_cur[i]]) begin
            moved = 1; m_cur[i] = m_cur[i] - 1;
          end else if (TO_V[i] != 0 && m_cur[i] != 0 && m_dwell[i] == TO_V[i] - 1) begin
            moved = 1; fire = 1; m_cur[i] = 0;
          end
          m_dwell[i] = moved ? 0 : ((m_dwell[i] < 255) ? m_dwell[i] + 1 : 255);
          m_done[i]  = wrap;
          m_to[i]    = fire ? 1'b1 : (err_clr ? 1'b0 : m_to[i]);
          m_il[i]    = ill  ? 1'b1 : (err_clr ? 1'b0 : m_il[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [3:0] st, input logic [1:0] idx,
                     input logic [1:0] zz, input logic dn, input logic [7:0] dw,
                     input logic te, input logic ie);
    bit bad;
    bad = (i == 0) && inject;
    chk($sformatf("m%0d.state_oh", i), st, bad ? 4'b0110 : (4'b0001 << m_cur[i]));
    chk($sformatf("m%0d.state_idx", i), idx, bad ? 0 : m_cur[i]);
    chk($sformatf("m%0d.z", i), zz, bad ? 0 : ZTAB[m_cur[i]]);
    chk($sformatf("m%0d.done", i), dn, m_done[i]);
    chk($sformatf("m%0d.dwell", i), dw, m_dwell[i]);
    chk($sformatf("m%0d.timeout_err", i), te, m_to[i]);
    chk($sformatf("m%0d.illegal_err", i), ie, m_il[i]);
  endtask

  always @(negedge clk) begin
    cmp(0, st0, idx0, z0, done0, dw0, to0, il0);
    cmp(1, st1, idx1, z1, done1, dw1, to1, il1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1; clr = 0; adv = 0; back = 0; err_clr = 0; inject = 0; rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk("rst_state", st0, 4'b0001);
    chk("rst_z", z0, 2'b01);
    chk("rst_done", done0, 0);

    // Full sequence with wrap
    adv = 4'b0001; step(); chk("seq_s1", st0, 4'b0010); chk("seq_z1", z0, 2'b10);
    adv = 4'b0010; step(); chk("seq_s2", st0, 4'b0100); chk("seq_z2", z0, 2'b01);
    adv = 4'b0100; step(); chk("seq_s3", st0, 4'b1000); chk("seq_z3", z0, 2'b11);
    chk("seq_nodone", done0, 0);
    adv = 4'b1000; step(); chk("seq_wrap", st0, 4'b0001); chk("seq_done", done0, 1);
    adv = 4'b0000; step(); chk("seq_done_off", done0, 0);

    // Priority and step-back
    adv = 4'b0001; step(); adv = 4'b0010; step();
    adv = 4'b0100; back = 4'b0100; step(); chk("adv_wins", st0, 4'b1000);
    adv = 4'b0000; back = 4'b1000; step(); chk("back_3_2", st0, 4'b0100);
    adv = 4'b0010; back = 4'b0000; step(); chk("other_adv_ignored", st0, 4'b0100);
    adv = 4'b0000; back = 4'b0100; step(); chk("back_2_1", st0, 4'b0010);
    back = 4'b0000; clr = 1; step(); chk("clr_s0", st0, 4'b0001); chk("clr_nodone", done0, 0);
    clr = 0; back = 4'b0001; step(); chk("back0_ignored", st0, 4'b0001);
    back = 4'b0000; step(); step(); chk("dwell_s0", dw0, 3);
    clr = 1; step(); chk("clr_dwell_reset", dw0, 0); clr = 0;

    // Timeout from stage 1
    adv = 4'b0001; step(); adv = 4'b0000; chk("to_enter", dw0, 0);
    repeat (9) step();
    chk("to_dwell9", dw0, 9); chk("to_still_s1", st0, 4'b0010);
    step();
    chk("to_fire_state", st0, 4'b0001); chk("to_fire_err", to0, 1);
    chk("to0_nofire", st1, 4'b0010); chk("to0_dwell", dw1, 10);

    // Second timeout coincident with err_clr: set wins
    adv = 4'b0001; step(); adv = 4'b0000;
    repeat (9) step();
    err_clr = 1; step(); chk("to_set_wins", to0, 1); chk("to2_state", st0, 4'b0001);
    step(); chk("err_clr_to", to0, 0); err_clr = 0;

    // Enable freeze in stage 3, then clr beats adv
    clr = 1; step(); clr = 0;
    adv = 4'b0001; step(); adv = 4'b0010; step(); adv = 4'b0100; step();
    en = 0; adv = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("en0_state", st0, 4'b1000); chk("en0_dwell", dw0, 0); chk("en0_done", done0, 0);
    end
    en = 1; clr = 1; step(); chk("clr_over_adv", st0, 4'b0001); chk("clr_adv_nodone", done0, 0);
    clr = 0; adv = 4'b0000; step(); chk("clr_adv_nodone2", done0, 0);

    // Illegal encoding recovery
    en = 0;
    force dut0.state_q = 4'b0110;
    inject = 1;
    #1 chk("ill_z", z0, 2'b00); chk("ill_idx", idx0, 0);
    step();
    release dut0.state_q;
    en = 1;
    step();
    inject = 0;
    chk("ill_recover", st0, 4'b0001); chk("ill_flag", il0, 1); chk("ill_dwell", dw0, 0);
    err_clr = 1; step(); chk("err_clr_il", il0, 0); err_clr = 0;

    // TIMEOUT=0 build: long idle in stage 1 saturates dwell
    clr = 1; step(); clr = 0;
    adv = 4'b0001; step(); adv = 4'b0000;
    repeat (300) step();
    chk("sat_dwell", dw1, 255); chk("sat_state", st1, 4'b0010); chk("sat_noto", to1, 0);
    chk("to_after_idle", to0, 1);

    // Asynchronous reset mid-run
    adv = 4'b0001; step(); adv = 4'b0000; step(); step();
    rst = 0;
    #1;
    chk("arst_state", st0, 4'b0001); chk("arst_z", z0, 2'b01); chk("arst_dwell", dw0, 0);
    chk("arst_to", to0, 0); chk("arst_il", il0, 0); chk("arst_dwell1", dw1, 0);
    repeat (2) step();
    rst = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
